// File: rtl/word_to_byte_unpack_tx_if.sv
// word_to_byte_unpack_tx_if: FIFO-side, PHY-side and packet-control signals of the tx byte unpacker
interface word_to_byte_unpack_tx_if #(parameter int LEN_W = 16);
  logic             start_i;
  logic [LEN_W-1:0] num_byte_i;
  logic [63:0]      word_in_i;
  logic             word_in_valid_i;
  logic             word_in_rd_o;
  logic             byte_req_i;
  logic [7:0]       byte_out_o;
  logic             byte_out_strobe_o;
  logic [LEN_W-1:0] byte_count_o;
  logic             last_byte_o;
  logic             busy_o;
  logic             done_o;
  logic             underrun_o;
  modport master (
    output start_i, num_byte_i, word_in_i, word_in_valid_i, byte_req_i,
    input  word_in_rd_o, byte_out_o, byte_out_strobe_o, byte_count_o, last_byte_o, busy_o, done_o, underrun_o
  );
  modport slave (
    input  start_i, num_byte_i, word_in_i, word_in_valid_i, byte_req_i,
    output word_in_rd_o, byte_out_o, byte_out_strobe_o, byte_count_o, last_byte_o, busy_o, done_o, underrun_o
  );
endinterface

// File: rtl/word_to_byte_unpack_tx.sv
// word_to_byte_unpack_tx: serialise FWFT 64-bit FIFO words into a PHY byte stream, word[7:0] first
module word_to_byte_unpack_tx #(parameter int LEN_W = 16) (
  input logic clk,
  input logic rstn,
  word_to_byte_unpack_tx_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d, need_q, need_d, fetched_q, fetched_d, sent_q, sent_d, count_q, count_d;
  logic [63:0] cur_q, cur_d, nxt_q, nxt_d;
  logic cur_v_q, cur_v_d, nxt_v_q, nxt_v_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] byte_q, byte_d;
  logic strobe_q, strobe_d, last_q, last_d, busy_q, busy_d, under_q, under_d;
  logic run, go, live, send, is_last, cur_free, move, fetch;
  // Handshake decode: live means bytes still owed; cur frees on word wrap or the final byte so nxt can slide in the same cycle
  always_comb begin
    run = state_q == RUN;
    go = state_q == IDLE && bus.start_i;
    live = run && sent_q != len_q;
    send = live && bus.byte_req_i && cur_v_q;
    is_last = sent_q == len_q - LEN_W'(1);
    cur_free = !cur_v_q || (send && (idx_q == 3'd7 || is_last));
    move = run && cur_free && nxt_v_q;
    fetch = run && (!nxt_v_q || move) && fetched_q < need_q && bus.word_in_valid_i;
  end
  // Next state: FSM sequencing, prefetch/active word buffers and registered byte outputs
  always_comb begin
    state_d = go ? (bus.num_byte_i == '0 ? DONE : RUN) : run ? (live ? RUN : DONE) : (state_q == DONE ? IDLE : state_q);
    len_d = go ? bus.num_byte_i : len_q;
    need_d = go ? LEN_W'(({1'b0, bus.num_byte_i} + (LEN_W + 1)'(7)) >> 3) : need_q;
    fetched_d = go ? '0 : fetched_q + LEN_W'(fetch);
    sent_d = go ? '0 : sent_q + LEN_W'(send);
    nxt_v_d = run && (fetch || (nxt_v_q && !move));
    nxt_d = fetch ? bus.word_in_i : nxt_q;
    cur_v_d = run && (move || (cur_v_q && !cur_free));
    cur_d = move ? nxt_q : cur_q;
    idx_d = move ? 3'd0 : idx_q + 3'(send);
    byte_d = send ? cur_q[{idx_q, 3'b000} +: 8] : byte_q;
    strobe_d = send;
    count_d = send ? sent_q : count_q;
    last_d = send && is_last;
    busy_d = go ? bus.num_byte_i != '0 : (state_q == DONE ? 1'b0 : busy_q);
    under_d = go ? 1'b0 : under_q || (live && bus.byte_req_i && !cur_v_q);
  end
  // State register; reset abandons any packet in flight without a done pulse
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      len_q <= '0;
      need_q <= '0;
      fetched_q <= '0;
      sent_q <= '0;
      count_q <= '0;
      cur_q <= '0;
      nxt_q <= '0;
      cur_v_q <= 1'b0;
      nxt_v_q <= 1'b0;
      idx_q <= '0;
      byte_q <= '0;
      strobe_q <= 1'b0;
      last_q <= 1'b0;
      busy_q <= 1'b0;
      under_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      need_q <= need_d;
      fetched_q <= fetched_d;
      sent_q <= sent_d;
      count_q <= count_d;
      cur_q <= cur_d;
      nxt_q <= nxt_d;
      cur_v_q <= cur_v_d;
      nxt_v_q <= nxt_v_d;
      idx_q <= idx_d;
      byte_q <= byte_d;
      strobe_q <= strobe_d;
      last_q <= last_d;
      busy_q <= busy_d;
      under_q <= under_d;
    end
  end
  assign bus.word_in_rd_o = fetch;
  assign bus.byte_out_o = byte_q;
  assign bus.byte_out_strobe_o = strobe_q;
  assign bus.byte_count_o = count_q;
  assign bus.last_byte_o = last_q;
  assign bus.busy_o = busy_q;
  assign bus.done_o = state_q == DONE;
  assign bus.underrun_o = under_q;
endmodule

// File: tb/tb_word_to_byte_unpack_tx.sv
// tb_word_to_byte_unpack_tx: randomized and directed checks of the tx byte unpacker against a byte-queue model
module tb_word_to_byte_unpack_tx;
  localparam int LEN_W = 16;
  logic clk = 0;
  logic rstn = 0;
  always #5 clk = ~clk;
  word_to_byte_unpack_tx_if #(.LEN_W(LEN_W)) bus ();
  word_to_byte_unpack_tx #(.LEN_W(LEN_W)) dut (.clk(clk), .rstn(rstn), .bus(bus));
  int tests, fails, cyc, n, exp_len, exp_words, pops, dones, first_cyc, last_cyc, req_mode;
  bit rand_vis, prev_live, dropped, last_prev, done_prev, pop_s;
  logic [7:0] exp_b[$];
  logic [63:0] fifo[$];
  logic [63:0] words[$];
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic check_idle(string tag);
    check({tag, "_byte"}, bus.byte_out_o, 0);
    check({tag, "_strobe"}, bus.byte_out_strobe_o, 0);
    check({tag, "_count"}, bus.byte_count_o, 0);
    check({tag, "_last"}, bus.last_byte_o, 0);
    check({tag, "_busy"}, bus.busy_o, 0);
    check({tag, "_done"}, bus.done_o, 0);
    check({tag, "_underrun"}, bus.underrun_o, 0);
    check({tag, "_rd"}, bus.word_in_rd_o, 0);
  endtask
  // FIFO and PHY request model, updated just after each rising edge
  always @(posedge clk) begin
    #1;
    if (pop_s && fifo.size() > 0) void'(fifo.pop_front());
    bus.word_in_valid_i = fifo.size() > 0 && (!rand_vis || $urandom_range(0, 3) != 0);
    bus.word_in_i = fifo.size() > 0 ? fifo[0] : '0;
    bus.byte_req_i = req_mode == 1 || (req_mode == 2 && cyc % 4 == 0) || (req_mode == 3 && $urandom_range(0, 2) != 0);
  end
  // Scoreboard: a live request must yield the next expected byte one cycle later, otherwise it counts as a drop
  always @(negedge clk) begin
    cyc++;
    pop_s = bus.word_in_rd_o === 1'b1;
    if (!rstn) begin
      prev_live = 0;
      done_prev = 0;
    end else begin
      if (pop_s) begin
        pops++;
        check("rd_valid", bus.word_in_valid_i, 1);
      end
      if (bus.byte_out_strobe_o) begin
        check("strobe_after_req", prev_live, 1);
        if (n >= exp_len) check("extra_strobe", n, exp_len);
        else begin
          check("byte", bus.byte_out_o, exp_b[n]);
          check("count", bus.byte_count_o, n);
          check("last", bus.last_byte_o, n == exp_len - 1);
        end
        if (n == 0) first_cyc = cyc;
        last_cyc = cyc;
        n++;
      end else begin
        if (prev_live) dropped = 1;
        check("last_idle", bus.last_byte_o, 0);
      end
      if (bus.busy_o && !bus.done_o) check("underrun", bus.underrun_o, dropped);
      if (bus.done_o) begin
        check("done_bytes", n, exp_len);
        check("done_pops", pops, exp_words);
        check("done_after_last", last_prev, exp_len != 0);
        check("done_pulse", done_prev, 0);
        dones++;
      end
      done_prev = bus.done_o;
      last_prev = bus.byte_out_strobe_o && bus.last_byte_o;
      prev_live = bus.byte_req_i && bus.busy_o && !bus.done_o && n < exp_len;
    end
  end
  task automatic start_pkt(int len, int avail);
    int t = 0;
    while (bus.busy_o && t < 500) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    #1;
    exp_b.delete();
    for (int i = 0; i < len; i++) exp_b.push_back(8'(words[i / 8] >> (8 * (i % 8))));
    exp_len = len;
    exp_words = (len + 7) / 8;
    n = 0;
    pops = 0;
    dropped = 0;
    last_prev = 0;
    for (int i = 0; i < avail; i++) fifo.push_back(words[i]);
    bus.start_i = 1;
    bus.num_byte_i = LEN_W'(len);
    @(posedge clk);
    #1;
    bus.start_i = 0;
  endtask
  task automatic wait_done(int budget, string tag);
    int d0 = dones;
    int t = 0;
    while (dones == d0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_done_seen"}, dones != d0, 1);
  endtask
  task automatic wait_bytes(int cnt, string tag);
    int t = 0;
    while (n < cnt && t < 300) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_bytes_reached"}, n >= cnt, 1);
  endtask
  task automatic rand_words(int cnt);
    words.delete();
    for (int i = 0; i < cnt; i++) words.push_back({$urandom, $urandom});
  endtask
  initial begin
    int d0, len;
    bus.start_i = 0;
    bus.num_byte_i = '0;
    bus.word_in_i = '0;
    bus.word_in_valid_i = 0;
    bus.byte_req_i = 0;
    req_mode = 0;
    rand_vis = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    @(posedge clk);
    #1;
    rstn = 1;
    words.delete();
    words.push_back(64'h0706050403020100);
    words.push_back(64'h0F0E0D0C0B0A0908);
    req_mode = 1;
    start_pkt(16, 2);
    wait_done(200, "t1");
    check("t1_back_to_back", last_cyc - first_cyc, 15);
    check("t1_fifo_empty", fifo.size(), 0);
    words.delete();
    words.push_back(64'h8877665544332211);
    start_pkt(5, 1);
    wait_done(200, "t2");
    check("t2_fifo_empty", fifo.size(), 0);
    req_mode = 0;
    start_pkt(0, 0);
    @(negedge clk);
    check("t3_done", bus.done_o, 1);
    check("t3_busy", bus.busy_o, 0);
    @(negedge clk);
    check("t3_done_end", bus.done_o, 0);
    check("t3_busy_end", bus.busy_o, 0);
    rand_words(2);
    req_mode = 1;
    start_pkt(12, 1);
    repeat (30) @(negedge clk);
    check("t4_stall_bytes", n, 8);
    check("t4_underrun", bus.underrun_o, 1);
    fifo.push_back(words[1]);
    wait_done(200, "t4");
    rand_words(2);
    req_mode = 2;
    start_pkt(9, 2);
    @(negedge clk);
    check("t5_underrun_clr", bus.underrun_o, 0);
    wait_done(300, "t5");
    rand_words(2);
    req_mode = 1;
    start_pkt(16, 2);
    wait_bytes(1, "t6a");
    @(posedge clk);
    #1;
    bus.start_i = 1;
    bus.num_byte_i = LEN_W'(3);
    @(posedge clk);
    #1;
    bus.start_i = 0;
    wait_bytes(3, "t6b");
    d0 = dones;
    @(posedge clk);
    #1;
    rstn = 0;
    @(posedge clk);
    @(negedge clk);
    check_idle("t6_rst");
    @(posedge clk);
    #1;
    rstn = 1;
    fifo.delete();
    exp_len = 0;
    repeat (5) @(negedge clk);
    check("t6_no_done", dones, d0);
    rand_words(2);
    start_pkt(13, 2);
    wait_done(200, "t6_restart");
    rand_vis = 1;
    req_mode = 3;
    repeat (25) begin
      len = $urandom_range(0, 40);
      rand_words((len + 7) / 8);
      start_pkt(len, (len + 7) / 8);
      wait_done(3000, "rnd");
      check("rnd_fifo_empty", fifo.size(), 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
